done_delay_sched: RTL and testbench

- Multi-channel, parametrised successor to the single done-compute delay stage in the controller.
- Each channel holds a compute-done indication back by a programmable layer-dependent latency, delay = (IFM_C * OFM_C) >> SHIFT, before signalling the downstream stage (writeback / next-layer start).
- Adds features the single-channel version lacks:
  - per-channel config latching
  - pulse or level output mode
  - abort on done deassertion
  - saturation flag
  - global flush

---
 rtl/done_delay_pkg.sv | 9 +
 rtl/done_delay_lane.sv | 128 ++++++++++++
 rtl/done_delay_sched.sv | 45 ++++
 tb/tb_done_delay_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/done_delay_pkg.sv
// Shared state encoding and output-mode constants for the done-delay scheduler.
package done_delay_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, FIRE, HOLD} dd_state_t;

  localparam logic MODE_PULSE = 1'b0;
  localparam logic MODE_LEVEL = 1'b1;

endpackage

// File: rtl/done_delay_lane.sv
// One delay channel: latches (IFM_C*OFM_C)>>SHIFT as its delay and holds a
// compute-done rising edge back by that many cycles plus one.
module done_delay_lane
  import done_delay_pkg::*;
#(
  parameter int DIM_W = 16,
  parameter int CNT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [DIM_W-1:0] ifm_c,
  input  logic [DIM_W-1:0] ofm_c,
  input  logic             cfg_mode,
  input  logic             flush,
  input  logic             done_compute,
  output logic             done_compute_delay,
  output logic             busy,
  output logic             cfg_sat
);

  localparam int PROD_W = 2 * DIM_W;

  dd_state_t          state_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   delay_reg;
  logic               mode_reg;
  logic               sat_reg;
  logic               done_prev_reg;
  logic               out_reg;
  logic               busy_reg;

  logic [PROD_W-1:0]  prod;
  logic [PROD_W-1:0]  shifted;
  logic [CNT_W-1:0]   delay_calc;
  logic               sat_calc;
  logic               rise;

  // Full-width product so large dimensions are never truncated before the shift.
  assign prod    = {{DIM_W{1'b0}}, ifm_c} * {{DIM_W{1'b0}}, ofm_c};
  assign shifted = prod >> SHIFT;
  assign rise    = done_compute & ~done_prev_reg;

  generate
    if (CNT_W < PROD_W) begin : g_clamp
      assign sat_calc   = |shifted[PROD_W-1:CNT_W];
      assign delay_calc = sat_calc ? {CNT_W{1'b1}} : shifted[CNT_W-1:0];
    end else begin : g_no_clamp
      assign sat_calc   = 1'b0;
      assign delay_calc = CNT_W'(shifted);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      delay_reg     <= '0;
      mode_reg      <= MODE_PULSE;
      sat_reg       <= 1'b0;
      done_prev_reg <= 1'b0;
      out_reg       <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      done_prev_reg <= done_compute;
      // Config is independent of flush; it only changes while the lane is idle.
      if (cfg_load && state_reg == IDLE) begin
        delay_reg <= delay_calc;
        mode_reg  <= cfg_mode;
        sat_reg   <= sat_calc;
      end
      if (flush) begin
        state_reg <= IDLE;
        count_reg <= '0;
        out_reg   <= 1'b0;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (rise) begin
              state_reg <= COUNT;
              count_reg <= '0;
              busy_reg  <= 1'b1;
            end
          end
          COUNT: begin
            if (!done_compute) begin
              state_reg <= IDLE;
              count_reg <= '0;
              busy_reg  <= 1'b0;
            end else if (count_reg == delay_reg) begin
              state_reg <= (mode_reg == MODE_LEVEL) ? HOLD : FIRE;
              out_reg   <= 1'b1;
            end else begin
              count_reg <= count_reg + CNT_W'(1);
            end
          end
          FIRE: begin
            state_reg <= IDLE;
            count_reg <= '0;
            out_reg   <= 1'b0;
            busy_reg  <= 1'b0;
          end
          HOLD: begin
            if (!done_compute) begin
              state_reg <= IDLE;
              count_reg <= '0;
              out_reg   <= 1'b0;
              busy_reg  <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE;
            count_reg <= '0;
            out_reg   <= 1'b0;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign done_compute_delay = out_reg;
  assign busy               = busy_reg;
  assign cfg_sat            = sat_reg;

endmodule

// File: rtl/done_delay_sched.sv
// Multi-channel done-delay scheduler: NUM_CH independent lanes sharing flush and reset.
module done_delay_sched
  import done_delay_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIM_W  = 16,
  parameter int CNT_W  = 32,
  parameter int SHIFT  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       cfg_load,
  input  logic [NUM_CH*DIM_W-1:0] ifm_c,
  input  logic [NUM_CH*DIM_W-1:0] ofm_c,
  input  logic [NUM_CH-1:0]       cfg_mode,
  input  logic                    flush,
  input  logic [NUM_CH-1:0]       done_compute,
  output logic [NUM_CH-1:0]       done_compute_delay,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       cfg_sat
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      done_delay_lane #(
        .DIM_W (DIM_W),
        .CNT_W (CNT_W),
        .SHIFT (SHIFT)
      ) u_lane (
        .clk                (clk),
        .rst_n              (rst_n),
        .cfg_load           (cfg_load[gi]),
        .ifm_c              (ifm_c[gi*DIM_W +: DIM_W]),
        .ofm_c              (ofm_c[gi*DIM_W +: DIM_W]),
        .cfg_mode           (cfg_mode[gi]),
        .flush              (flush),
        .done_compute       (done_compute[gi]),
        .done_compute_delay (done_compute_delay[gi]),
        .busy               (busy[gi]),
        .cfg_sat            (cfg_sat[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_done_delay_sched.sv
// Self-checking bench: latency-arithmetic reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_done_delay_sched;

  localparam int NUM_CH = 2;
  localparam int DIM_W  = 16;
  localparam int CNT_W  = 8;
  localparam int SHIFT  = 2;
  localparam longint MAXD = (64'd1 << CNT_W) - 1;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH-1:0]       cfg_load;
  logic [NUM_CH*DIM_W-1:0] ifm_c;
  logic [NUM_CH*DIM_W-1:0] ofm_c;
  logic [NUM_CH-1:0]       cfg_mode;
  logic                    flush;
  logic [NUM_CH-1:0]       done_compute;
  logic [NUM_CH-1:0]       done_compute_delay;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       cfg_sat;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  done_delay_sched #(
    .NUM_CH (NUM_CH),
    .DIM_W  (DIM_W),
    .CNT_W  (CNT_W),
    .SHIFT  (SHIFT)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_load           (cfg_load),
    .ifm_c              (ifm_c),
    .ofm_c              (ofm_c),
    .cfg_mode           (cfg_mode),
    .flush              (flush),
    .done_compute       (done_compute),
    .done_compute_delay (done_compute_delay),
    .busy               (busy),
    .cfg_sat            (cfg_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a channel that started at edge S fires at edge S+delay+1.
  bit     m_busy  [NUM_CH];
  bit     m_out   [NUM_CH];
  bit     m_mode  [NUM_CH];
  bit     m_sat   [NUM_CH];
  bit     m_prev  [NUM_CH];
  longint m_delay [NUM_CH];
  longint m_start [NUM_CH];
  longint cyc = 0;

  always @(posedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bit     d;
      bit     rise;
      longint p;
      d    = done_compute[ch];
      rise = d && !m_prev[ch];
      if (!rst_n) begin
        m_busy[ch] = 0; m_out[ch] = 0; m_mode[ch] = 0; m_sat[ch] = 0;
        m_prev[ch] = 0; m_delay[ch] = 0; m_start[ch] = 0;
      end else begin
        if (cfg_load[ch] && !m_busy[ch]) begin
          p = (longint'(ifm_c[ch*DIM_W +: DIM_W]) * longint'(ofm_c[ch*DIM_W +: DIM_W])) >> SHIFT;
          m_sat[ch]   = (p > MAXD);
          m_delay[ch] = m_sat[ch] ? MAXD : p;
          m_mode[ch]  = cfg_mode[ch];
        end
        if (flush) begin
          m_busy[ch] = 0; m_out[ch] = 0;
        end else if (!m_busy[ch]) begin
          if (rise) begin
            m_busy[ch] = 1; m_out[ch] = 0; m_start[ch] = cyc;
          end
        end else if (m_out[ch]) begin
          if (m_mode[ch] == 1'b0 || !d) begin
            m_busy[ch] = 0; m_out[ch] = 0;
          end
        end else if (!d) begin
          m_busy[ch] = 0;
        end else if (cyc - m_start[ch] == m_delay[ch] + 1) begin
          m_out[ch] = 1;
        end
        m_prev[ch] = d;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NUM_CH-1:0] eo, eb, es;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        eo[ch] = m_out[ch]; eb[ch] = m_busy[ch]; es[ch] = m_sat[ch];
      end
      tests += 3;
      if (done_compute_delay !== eo) begin
        fails++;
        $display("FAIL model_out cyc=%0d got=%b exp=%b", cyc, done_compute_delay, eo);
      end
      if (busy !== eb) begin
        fails++;
        $display("FAIL model_busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
      end
      if (cfg_sat !== es) begin
        fails++;
        $display("FAIL model_sat cyc=%0d got=%b exp=%b", cyc, cfg_sat, es);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end else begin
      $display("[TB] %s ok value=%0d", name, act);
    end
  endtask

  task automatic load(input int ch, input int a, input int b, input bit mode);
    ifm_c[ch*DIM_W +: DIM_W] = DIM_W'(a);
    ofm_c[ch*DIM_W +: DIM_W] = DIM_W'(b);
    cfg_mode[ch] = mode;
    cfg_load[ch] = 1'b1;
    tick();
    cfg_load[ch] = 1'b0;
  endtask

  // Counts negedges until the channel output is seen high; -1 on timeout.
  task automatic wait_out(input int ch, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done_compute_delay[ch] && n <= budget);
    if (!done_compute_delay[ch]) begin
      tests++;
      fails++;
      $display("FAIL wait_out_timeout ch=%0d got=no_output exp=output_within_%0d", ch, budget);
      n = -1;
    end
  endtask

  int n;

  initial begin
    rst_n = 0; flush = 0; cfg_load = '0; cfg_mode = '0; done_compute = '0;
    ifm_c = '0; ofm_c = '0;
    tick(); tick();
    chk_en = 1;
    check("reset_out", longint'(done_compute_delay), 0);
    check("reset_busy", longint'(busy), 0);
    rst_n = 1;
    tick();

    // 1: pulse, 8*16>>2 = 32 -> output after 33 edges, one cycle wide
    load(0, 8, 16, 1'b0);
    check("t1_model_delay", m_delay[0], 32);
    check("t1_sat", longint'(cfg_sat[0]), 0);
    done_compute[0] = 1;
    wait_out(0, 300, n);
    check("t1_latency", n - 1, 33);
    tick();
    check("t1_pulse_width", longint'(done_compute_delay[0]), 0);
    done_compute[0] = 0;
    tick();

    // 2: level, 4*4>>2 = 4 -> latency 5, held until done drops
    load(1, 4, 4, 1'b1);
    done_compute[1] = 1;
    wait_out(1, 300, n);
    check("t2_latency", n - 1, 5);
    repeat (14) tick();
    check("t2_level_hold", longint'(done_compute_delay[1]), 1);
    done_compute[1] = 0;
    tick();
    check("t2_level_fall", longint'(done_compute_delay[1]), 0);

    // 3: abort after 10 cycles, then a fresh rise restarts from zero
    done_compute[0] = 1;
    repeat (10) tick();
    done_compute[0] = 0;
    tick();
    check("t3_abort_busy", longint'(busy[0]), 0);
    repeat (40) tick();
    done_compute[0] = 1;
    wait_out(0, 300, n);
    check("t3_restart_latency", n - 1, 33);
    done_compute[0] = 0;
    tick(); tick();

    // 4: saturation 40*40>>2 = 400 -> 255, then zero delay
    load(1, 40, 40, 1'b1);
    check("t4_sat", longint'(cfg_sat[1]), 1);
    check("t4_model_delay", m_delay[1], 255);
    done_compute[1] = 1;
    wait_out(1, 400, n);
    check("t4_sat_latency", n - 1, 256);
    done_compute[1] = 0;
    tick();
    load(1, 0, 5, 1'b0);
    check("t4_zero_sat", longint'(cfg_sat[1]), 0);
    done_compute[1] = 1;
    wait_out(1, 50, n);
    check("t4_zero_latency", n - 1, 1);
    done_compute[1] = 0;
    tick();

    // 5: load mid-count ignored; load coincident with rise used
    done_compute[0] = 1;
    repeat (6) tick();
    load(0, 8, 2, 1'b0);
    wait_out(0, 300, n);
    check("t5_midcount_latency", 7 + n - 1, 33);
    done_compute[0] = 0;
    tick();
    ifm_c[0 +: DIM_W] = 16'd4; ofm_c[0 +: DIM_W] = 16'd4; cfg_mode[0] = 1'b0;
    cfg_load[0] = 1; done_compute[0] = 1;
    tick();
    cfg_load[0] = 0;
    wait_out(0, 300, n);
    check("t5_coincident_latency", n, 5);
    done_compute[0] = 0;
    tick();

    // 6: flush mid-count on both lanes, retained config, reset mid-hold
    load(1, 8, 8, 1'b1);
    done_compute = 2'b11;
    repeat (5) tick();
    flush = 1;
    tick();
    flush = 0;
    check("t6_flush_busy", longint'(busy), 0);
    check("t6_flush_out", longint'(done_compute_delay), 0);
    repeat (3) tick();
    check("t6_no_restart_busy", longint'(busy), 0);
    done_compute = 2'b00;
    tick();
    done_compute[0] = 1;
    wait_out(0, 300, n);
    check("t6_after_flush_latency", n - 1, 5);
    done_compute[0] = 0;
    tick();
    done_compute[1] = 1;
    wait_out(1, 300, n);
    check("t6_ch1_latency", n - 1, 17);
    repeat (3) tick();
    rst_n = 0;
    tick();
    check("t6_rst_out", longint'(done_compute_delay), 0);
    check("t6_rst_busy", longint'(busy), 0);
    rst_n = 1;
    done_compute = '0;
    tick();

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      flush = ($urandom_range(0, 149) == 0);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if ($urandom_range(0, 11) == 0) done_compute[ch] = ~done_compute[ch];
        cfg_load[ch] = !flush && ($urandom_range(0, 9) == 0);
        cfg_mode[ch] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) begin
          ifm_c[ch*DIM_W +: DIM_W] = DIM_W'($urandom_range(30, 60));
          ofm_c[ch*DIM_W +: DIM_W] = DIM_W'($urandom_range(30, 60));
        end else begin
          ifm_c[ch*DIM_W +: DIM_W] = DIM_W'($urandom_range(0, 12));
          ofm_c[ch*DIM_W +: DIM_W] = DIM_W'($urandom_range(0, 12));
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
